// File: rtl/rom_seq_pkg.sv
// Shared state encoding and flash placement for the QSPI ROM prefetch sequencer.
package rom_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } seq_state_e;

  localparam logic [23:0] FLASH_BASE = 24'h100000;

endpackage

// File: rtl/prefetch_window_buf.sv
// DEPTH x 8 circular buffer holding the sliding prefetch window; reads at an
// offset from the oldest byte and can drop leading bytes while a new one arrives.
module prefetch_window_buf #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          adv_i,
  input  logic [PW:0]   off_i,
  input  logic          push_i,
  input  logic [7:0]    push_data_i,
  output logic [7:0]    rd_data_o,
  output logic [PW:0]   count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW:0]   count_q;
  logic [PW-1:0] rd_idx;

  assign rd_idx    = rd_ptr_q + off_i[PW-1:0];
  assign rd_data_o = mem_q[rd_idx];
  assign count_o   = count_q;

  // NOTE: the byte storage is deliberately not reset; count_q alone decides
  // which entries are meaningful, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: all state updates are non-blocking so the hit read and the push in
  // the same cycle both see the pre-update window.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (adv_i)  rd_ptr_q <= rd_ptr_q + off_i[PW-1:0];
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      count_q <= count_q - (adv_i ? off_i : '0) + {{PW{1'b0}}, push_i};
    end
  end

endmodule

// File: rtl/qspi_rom_prefetch_sequencer.sv
// Serves 6507 cartridge-ROM reads from a sequential flash prefetch window and
// restarts the QSPI flash stream whenever the CPU leaves that window.
module qspi_rom_prefetch_sequencer
  import rom_seq_pkg::*;
#(
  parameter int                    DEPTH      = 4,
  parameter int                    ADDR_BITS  = 12,
  parameter int                    FLASH_BITS = 24,
  parameter logic [FLASH_BITS-1:0] FLASH_BASE = rom_seq_pkg::FLASH_BASE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rom_req,
  input  logic [ADDR_BITS-1:0]  rom_addr,
  output logic                  rom_wait,
  output logic [7:0]            rom_data,
  output logic [FLASH_BITS-1:0] fl_addr,
  output logic                  fl_start_read,
  output logic                  fl_stop_read,
  output logic                  fl_stall_read,
  input  logic [7:0]            fl_data,
  input  logic                  fl_data_ready,
  input  logic                  fl_busy,
  output logic [15:0]           miss_count
);

  localparam int          PW         = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

  seq_state_e            state_q;
  logic [ADDR_BITS-1:0]  base_q;
  logic [ADDR_BITS-1:0]  pend_q;
  logic [FLASH_BITS-1:0] fl_addr_q;
  logic [7:0]            rom_data_q;
  logic [15:0]           miss_count_q;
  logic                  start_q;
  logic                  stop_q;

  logic [ADDR_BITS-1:0]  off;
  logic [ADDR_BITS-1:0]  restart_addr;
  logic [PW:0]           win_count;
  logic [7:0]            win_rd_data;
  logic                  full, hit, nxt, miss, consume, win_clear;

  assign off  = rom_addr - base_q;
  assign full = (win_count == FULL_COUNT);
  assign hit  = rom_req && (off < ADDR_BITS'(win_count));
  // A full window cannot grow, so the byte just past it must restart the stream.
  assign nxt  = rom_req && (off == ADDR_BITS'(win_count)) && (state_q == STREAM) && !full;
  assign miss = rom_req && !hit && !nxt;

  assign restart_addr = rom_req ? rom_addr : pend_q;
  assign consume      = fl_data_ready && !full && (state_q == STREAM) && !miss;
  assign win_clear    = (state_q != STREAM) || miss;

  assign rom_wait      = rom_req && !hit;
  assign rom_data      = rom_data_q;
  assign fl_addr       = fl_addr_q;
  assign fl_start_read = start_q;
  assign fl_stop_read  = stop_q;
  assign fl_stall_read = full;
  assign miss_count    = miss_count_q;

  prefetch_window_buf #(
    .DEPTH(DEPTH)
  ) u_window (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (win_clear),
    .adv_i      (hit),
    .off_i      (off[PW:0]),
    .push_i     (consume),
    .push_data_i(fl_data),
    .rd_data_o  (win_rd_data),
    .count_o    (win_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      pend_q       <= '0;
      fl_addr_q    <= '0;
      rom_data_q   <= '0;
      miss_count_q <= '0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;

      if (hit) begin
        rom_data_q <= win_rd_data;
        base_q     <= rom_addr;
      end

      // Counted once per miss event; waiting in DRAIN is not a new miss.
      if (miss && (state_q != DRAIN) && (miss_count_q != 16'hFFFF))
        miss_count_q <= miss_count_q + 16'd1;

      unique case (state_q)
        IDLE: begin
          if (miss) begin
            fl_addr_q <= FLASH_BASE + FLASH_BITS'(rom_addr);
            start_q   <= 1'b1;
            base_q    <= rom_addr;
            state_q   <= STREAM;
          end
        end
        STREAM: begin
          if (miss) begin
            stop_q  <= 1'b1;
            pend_q  <= rom_addr;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!fl_busy) begin
            fl_addr_q <= FLASH_BASE + FLASH_BITS'(restart_addr);
            start_q   <= 1'b1;
            base_q    <= restart_addr;
            state_q   <= STREAM;
          end else if (rom_req) begin
            pend_q <= rom_addr;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_rom_prefetch_sequencer.sv
// Self-checking bench: behavioural QSPI flash responder, table-driven CPU reads,
// hand-written corner sequences and a randomized read phase.
module tb_qspi_rom_prefetch_sequencer;

  localparam logic [23:0] FBASE      = 24'h100000;
  localparam int          CMD_LAT    = 4;
  localparam int          STOP_LAT   = 3;
  localparam int          WAIT_LIMIT = 200;

  logic        clk;
  logic        rst_n;
  logic        rom_req;
  logic [11:0] rom_addr;
  logic        rom_wait;
  logic [7:0]  rom_data;
  logic [23:0] fl_addr;
  logic        fl_start_read;
  logic        fl_stop_read;
  logic        fl_stall_read;
  logic [7:0]  fl_data;
  logic        fl_data_ready;
  logic        fl_busy;
  logic [15:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;
  int starts   = 0;
  int stops    = 0;
  bit fm_gap_rand = 1'b0;

  qspi_rom_prefetch_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rom_req      (rom_req),
    .rom_addr     (rom_addr),
    .rom_wait     (rom_wait),
    .rom_data     (rom_data),
    .fl_addr      (fl_addr),
    .fl_start_read(fl_start_read),
    .fl_stop_read (fl_stop_read),
    .fl_stall_read(fl_stall_read),
    .fl_data      (fl_data),
    .fl_data_ready(fl_data_ready),
    .fl_busy      (fl_busy),
    .miss_count   (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ {a[3:0], a[7:4]} ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Flash controller model: updates at negedge, samples the DUT just before posedge.
  initial begin : flash_model
    logic        active;
    logic [23:0] addr;
    int          cnt, tail;
    logic        s_rst, s_took, s_start, s_stop, s_busy_prev;
    logic [23:0] s_faddr;
    active = 1'b0; addr = '0; cnt = 0; tail = 0;
    s_rst = 1'b0; s_took = 1'b0; s_start = 1'b0; s_stop = 1'b0; s_busy_prev = 1'b0;
    s_faddr = '0;
    fl_data = '0; fl_data_ready = 1'b0; fl_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tail > 0) tail--;
      if (!s_rst) begin
        active = 1'b0; fl_data_ready = 1'b0; tail = 0;
      end else if (s_stop) begin
        active = 1'b0; fl_data_ready = 1'b0; tail = STOP_LAT;
      end else if (s_start) begin
        active = 1'b1; addr = s_faddr; cnt = CMD_LAT; fl_data_ready = 1'b0;
      end else if (active) begin
        if (fl_data_ready && s_took) begin
          addr++;
          fl_data_ready = 1'b0;
          cnt = fm_gap_rand ? int'($urandom_range(0, 2)) : 1;
        end
        if (!fl_data_ready) begin
          if (cnt == 0) begin
            fl_data_ready = 1'b1;
            fl_data = mem_byte(addr);
          end else begin
            cnt--;
          end
        end
      end
      fl_busy = active || (tail > 0);
      #4;
      s_rst   = rst_n;
      s_took  = fl_data_ready && !fl_stall_read;
      s_start = fl_start_read;
      s_stop  = fl_stop_read;
      s_faddr = fl_addr;
      if (!rst_n) begin
        starts = 0;
        stops  = 0;
      end else begin
        if (fl_start_read) begin
          starts++;
          check("start_while_busy", 32'(s_busy_prev), 32'd0);
          check("start_stop_same_cycle", 32'(fl_stop_read), 32'd0);
          if (rom_req) check("start_addr", 32'(fl_addr), 32'(FBASE + {12'h000, rom_addr}));
        end
        if (fl_stop_read) stops++;
      end
      s_busy_prev = fl_busy;
    end
  end

  // Holds the request until accepted, then checks the byte delivered next cycle.
  task automatic cpu_read(input logic [11:0] a, output int waited);
    int n;
    rom_req  = 1'b1;
    rom_addr = a;
    n = 0;
    #1;
    while (rom_wait && n < WAIT_LIMIT) begin
      @(negedge clk);
      #1;
      n++;
    end
    check($sformatf("accept_0x%03h", a), 32'(rom_wait), 32'd0);
    @(negedge clk);
    #1;
    check($sformatf("rom_data_0x%03h", a), 32'(rom_data), 32'(mem_byte(FBASE + {12'h000, a})));
    waited = n;
  endtask

  typedef struct {
    logic [11:0] addr;
    int          exp_wait;
    int          exp_miss;
    int          exp_starts;
    int          exp_stops;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int waited, s0, p0, cur, nxt_a, r;
    bit seen_stop;

    for (int i = 0; i <= 16; i++)
      vecs.push_back('{12'(i), (i == 0) ? 1 : -1, 1, 1, 0});
    vecs.push_back('{12'h800, 1, 2, 2, 1});
    vecs.push_back('{12'h801, -1, 2, 2, 1});
    vecs.push_back('{12'h040, 1, 3, 3, 2});
    vecs.push_back('{12'h041, -1, 3, 3, 2});
    vecs.push_back('{12'h800, 1, 4, 4, 3});
    vecs.push_back('{12'h801, -1, 4, 4, 3});

    rst_n = 1'b0; rom_req = 1'b0; rom_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_miss_count", 32'(miss_count), 32'd0);
    check("rst_rom_data", 32'(rom_data), 32'd0);
    check("rst_start", 32'(fl_start_read), 32'd0);
    check("rst_stop", 32'(fl_stop_read), 32'd0);
    check("rst_stall", 32'(fl_stall_read), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold read, sequential streaming and mid-stream jumps.
    foreach (vecs[i]) begin
      cpu_read(vecs[i].addr, waited);
      if (vecs[i].exp_wait >= 0)
        check($sformatf("vec%0d_waited", i), 32'(waited != 0), 32'(vecs[i].exp_wait));
      check($sformatf("vec%0d_miss_count", i), 32'(miss_count), 32'(vecs[i].exp_miss));
      check($sformatf("vec%0d_starts", i), 32'(starts), 32'(vecs[i].exp_starts));
      check($sformatf("vec%0d_stops", i), 32'(stops), 32'(vecs[i].exp_stops));
    end

    // CPU idle: window fills to 0x801..0x804, then the far end hits and drains it.
    rom_req = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("full_stall", 32'(fl_stall_read), 32'd1);
    s0 = starts; p0 = stops;
    rom_addr = 12'h804; rom_req = 1'b1;
    #1;
    check("full_far_hit_wait", 32'(rom_wait), 32'd0);
    @(negedge clk);
    #1;
    check("full_far_hit_data", 32'(rom_data), 32'(mem_byte(FBASE + 24'h804)));
    check("full_drained_stall", 32'(fl_stall_read), 32'd0);

    // Same address held for five cycles: every cycle hits, no restart.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("repeat%0d_wait", k), 32'(rom_wait), 32'd0);
      check($sformatf("repeat%0d_data", k), 32'(rom_data), 32'(mem_byte(FBASE + 24'h804)));
    end
    check("repeat_no_start", 32'(starts), 32'(s0));
    check("repeat_no_stop", 32'(stops), 32'(p0));

    // Reset while draining after a jump.
    rom_addr = 12'h300;
    seen_stop = 1'b0;
    for (int k = 0; k < 20 && !seen_stop; k++) begin
      @(negedge clk);
      #1;
      seen_stop = fl_stop_read;
    end
    check("drain_stop_seen", 32'(seen_stop), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("drain_rst_miss_count", 32'(miss_count), 32'd0);
    check("drain_rst_rom_data", 32'(rom_data), 32'd0);
    check("drain_rst_start", 32'(fl_start_read), 32'd0);
    check("drain_rst_stop", 32'(fl_stop_read), 32'd0);
    check("drain_rst_stall", 32'(fl_stall_read), 32'd0);
    check("drain_rst_wait", 32'(rom_wait), 32'd1);
    rom_req = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("post_rst_no_start%0d", k), 32'(fl_start_read), 32'd0);
    end
    cpu_read(12'h020, waited);
    check("post_rst_cold_miss", 32'(miss_count), 32'd1);
    check("post_rst_cold_start", 32'(starts), 32'd1);

    // Randomized reads with variable flash byte timing.
    fm_gap_rand = 1'b1;
    cur = 'h020;
    for (int t = 0; t < 300; t++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45)      nxt_a = cur + 1;
      else if (r < 60) nxt_a = cur;
      else if (r < 75) nxt_a = cur + int'($urandom_range(0, 5));
      else if (r < 82) nxt_a = cur - int'($urandom_range(1, 3));
      else             nxt_a = int'($urandom_range(0, 'hEFF));
      if (nxt_a < 0 || nxt_a > 'hEF0) nxt_a = int'($urandom_range(0, 'h0FF));
      if ($urandom_range(0, 3) == 0) begin
        rom_req = 1'b0;
        repeat (int'($urandom_range(1, 3))) @(negedge clk);
      end
      cpu_read(12'(nxt_a), waited);
      cur = nxt_a;
    end
    rom_req = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("rand_miss_vs_starts", 32'(miss_count), 32'(starts));
    check("rand_miss_vs_stops", 32'(miss_count), 32'(stops + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
